// File: rtl/predictor_func_vadd_launcher.sv
// predictor_func_vadd_launcher: ap_ctrl_hs launcher that hands one operand set to a row-add child and returns its sums
//
// Ports:
//   ap_clk, ap_rst                    clock, asynchronous active-high reset
//   req_valid/req_ready, a0 a1 b0 b1  operand-set request handshake
//   child_ap_start/ready/done/idle    ap_ctrl_hs control to/from the child (idle is observation only)
//   child_a0 child_a1 child_b0 child_b1  registered operands to the child
//   child_s0/s1 (+_vld)               child results, captured while the child runs
//   res_valid/res_ready, s0 s1        result handshake and captured sums
//   err                               sticky watchdog error (only when VADD_LAUNCH_TIMEOUT_EN is defined)
//
// Build option: define VADD_LAUNCH_TIMEOUT_EN to add the TIMEOUT_CYCLES watchdog and the err port.
module predictor_func_vadd_launcher #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] a0,
    input  logic [63:0] a1,
    input  logic [63:0] b0,
    input  logic [63:0] b1,
    output logic        child_ap_start,
    input  logic        child_ap_ready,
    input  logic        child_ap_done,
    input  logic        child_ap_idle,
    output logic [63:0] child_a0,
    output logic [63:0] child_a1,
    output logic [63:0] child_b0,
    output logic [63:0] child_b1,
    input  logic [63:0] child_s0,
    input  logic [63:0] child_s1,
    input  logic        child_s0_vld,
    input  logic        child_s1_vld,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] s0,
    output logic [63:0] s1
`ifdef VADD_LAUNCH_TIMEOUT_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [63:0] child_a0_q, child_a0_d, child_a1_q, child_a1_d;
    logic [63:0] child_b0_q, child_b0_d, child_b1_q, child_b1_d;
    logic [63:0] s0_q, s0_d, s1_q, s1_d;
    logic        accept, run;
    logic        unused_idle;

    // child_ap_idle carries no control meaning for the launcher
    assign unused_idle = child_ap_idle;

    assign accept = (state_q == IDLE) && req_valid;
    assign run    = (state_q == START) || (state_q == WAIT);

`ifdef VADD_LAUNCH_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       timeout;
`else
    logic [7:0] unused_tmo;
    assign unused_tmo = 8'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = START;
            // ready and done together skip WAIT entirely
            START:   if (child_ap_ready) state_d = child_ap_done ? HOLD : WAIT;
            WAIT:    if (child_ap_done) state_d = HOLD;
            HOLD:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef VADD_LAUNCH_TIMEOUT_EN
        // counter is 0 in the first START cycle, so HOLD is entered TIMEOUT_CYCLES edges after START entry
        timeout = run && (cnt_q >= TMO_LAST) && (state_d != HOLD);
        if (timeout) state_d = HOLD;
        cnt_d = accept ? 8'd0 : run ? cnt_q + 8'd1 : cnt_q;
        err_d = err_q | timeout;
`endif
    end

    always_comb begin
        child_a0_d = accept ? a0 : child_a0_q;
        child_a1_d = accept ? a1 : child_a1_q;
        child_b0_d = accept ? b0 : child_b0_q;
        child_b1_d = accept ? b1 : child_b1_q;
        // a vld in the done cycle is still inside START/WAIT, so it is captured; later vlds overwrite
        s0_d = (run && child_s0_vld) ? child_s0 : s0_q;
        s1_d = (run && child_s1_vld) ? child_s1 : s1_q;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            child_a0_q <= '0;
            child_a1_q <= '0;
            child_b0_q <= '0;
            child_b1_q <= '0;
            s0_q       <= '0;
            s1_q       <= '0;
        end else begin
            state_q    <= state_d;
            child_a0_q <= child_a0_d;
            child_a1_q <= child_a1_d;
            child_b0_q <= child_b0_d;
            child_b1_q <= child_b1_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
        end
    end

`ifdef VADD_LAUNCH_TIMEOUT_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    // control outputs decode the state alone, so reset reaches them without waiting for a clock
    assign req_ready      = (state_q == IDLE);
    assign child_ap_start = (state_q == START);
    assign res_valid      = (state_q == HOLD);
    assign child_a0       = child_a0_q;
    assign child_a1       = child_a1_q;
    assign child_b0       = child_b0_q;
    assign child_b1       = child_b1_q;
    assign s0             = s0_q;
    assign s1             = s1_q;

endmodule

// File: tb/tb_predictor_func_vadd_launcher.sv
// tb_predictor_func_vadd_launcher: randomized self-checking bench with a behavioural child and result model
module tb_predictor_func_vadd_launcher;

    logic        ap_clk, ap_rst;
    logic        req_valid, req_ready;
    logic [63:0] a0, a1, b0, b1;
    logic        child_ap_start, child_ap_ready, child_ap_done, child_ap_idle;
    logic [63:0] child_a0, child_a1, child_b0, child_b1;
    logic [63:0] child_s0, child_s1;
    logic        child_s0_vld, child_s1_vld;
    logic        res_valid, res_ready;
    logic [63:0] s0, s1;
`ifdef VADD_LAUNCH_TIMEOUT_EN
    logic        err;
`endif

    int n_chk = 0;
    int n_pass = 0;
    logic [63:0] exp_s0 = '0;
    logic [63:0] exp_s1 = '0;

    predictor_func_vadd_launcher #(.TIMEOUT_CYCLES(16)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .child_ap_start(child_ap_start), .child_ap_ready(child_ap_ready),
        .child_ap_done(child_ap_done), .child_ap_idle(child_ap_idle),
        .child_a0(child_a0), .child_a1(child_a1), .child_b0(child_b0), .child_b1(child_b1),
        .child_s0(child_s0), .child_s1(child_s1),
        .child_s0_vld(child_s0_vld), .child_s1_vld(child_s1_vld),
        .res_valid(res_valid), .res_ready(res_ready),
        .s0(s0), .s1(s1)
`ifdef VADD_LAUNCH_TIMEOUT_EN
        , .err(err)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // One request: child asserts ready at cycle rdy_at and done at cycle done_at (cycle 0 = first start cycle),
    // optional early s0 vld at cycle 0, final vlds with the true sums in the done cycle, result held hold cycles.
    task automatic run_txn(input logic [63:0] xa0, xa1, xb0, xb1, input int rdy_at, done_at,
                           input bit v0, v1, early0, input logic [63:0] early_val, input int hold);
        logic [63:0] e0, e1;
        int starts;
        starts = 0;
        req_valid = 1'b1; a0 = xa0; a1 = xa1; b0 = xb0; b1 = xb1;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(negedge ap_clk);
        req_valid = 1'b0; a0 = ~xa0; a1 = ~xa1; b0 = ~xb0; b1 = ~xb1;
        e0 = v0 ? xa0 + xb0 : early0 ? early_val : exp_s0;
        e1 = v1 ? xa1 + xb1 : exp_s1;
        for (int c = 0; c <= done_at; c++) begin
            chk("start_run", 64'(child_ap_start), 64'(c <= rdy_at));
            if (child_ap_start) starts++;
            chk("res_valid_run", 64'(res_valid), 64'd0);
            chk("req_ready_run", 64'(req_ready), 64'd0);
            chk("child_a0", child_a0, xa0);
            chk("child_a1", child_a1, xa1);
            chk("child_b0", child_b0, xb0);
            chk("child_b1", child_b1, xb1);
            child_ap_ready = (c == rdy_at);
            child_ap_done  = (c == done_at);
            child_s0_vld   = (v0 && c == done_at) || (early0 && c == 0);
            child_s0       = (c == done_at) ? xa0 + xb0 : early_val;
            child_s1_vld   = v1 && c == done_at;
            child_s1       = xa1 + xb1;
            @(negedge ap_clk);
        end
        child_ap_ready = 1'b0; child_ap_done = 1'b0;
        child_s0_vld = 1'b0; child_s1_vld = 1'b0;
        child_s0 = r64(); child_s1 = r64();
        chk("start_cycles", 64'(starts), 64'(rdy_at + 1));
        exp_s0 = e0; exp_s1 = e1;
        for (int h = 0; h <= hold; h++) begin
            chk("res_valid_hold", 64'(res_valid), 64'd1);
            chk("s0_hold", s0, e0);
            chk("s1_hold", s1, e1);
            chk("req_ready_hold", 64'(req_ready), 64'd0);
            chk("start_hold", 64'(child_ap_start), 64'd0);
            chk("child_a0_hold", child_a0, xa0);
            res_ready = (h == hold);
            req_valid = (h < hold);
            @(negedge ap_clk);
        end
        res_ready = 1'b0; req_valid = 1'b0;
        chk("res_valid_done", 64'(res_valid), 64'd0);
        chk("req_ready_done", 64'(req_ready), 64'd1);
        chk("s0_after", s0, e0);
    endtask

    initial begin
        logic [63:0] v;
        int r, d;
        ap_rst = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        child_ap_ready = 1'b0; child_ap_done = 1'b0; child_ap_idle = 1'b1;
        child_s0 = '0; child_s1 = '0; child_s0_vld = 1'b0; child_s1_vld = 1'b0;
        repeat (2) @(negedge ap_clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_start", 64'(child_ap_start), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_s0", s0, 64'd0);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        run_txn(64'd1, 64'd2, 64'd10, 64'd20, 3, 3, 1, 1, 0, 64'd0, 0);
        chk("basic_s0", s0, 64'd11);
        chk("basic_s1", s1, 64'd22);
        run_txn(r64(), r64(), r64(), r64(), 0, 0, 1, 1, 0, 64'd0, 0);
        run_txn(r64(), r64(), r64(), r64(), 2, 2, 1, 1, 0, 64'd0, 1);
        run_txn(r64(), r64(), r64(), r64(), 1, 4, 1, 1, 0, 64'd0, 5);
        run_txn(64'd3, r64(), 64'd4, r64(), 1, 4, 1, 1, 1, 64'd5, 0);
        chk("s0_last_vld", s0, 64'd7);
        run_txn(r64(), r64(), r64(), r64(), 0, 2, 1, 0, 0, 64'd0, 0);

`ifdef VADD_LAUNCH_TIMEOUT_EN
        chk("err_clear", 64'(err), 64'd0);
        v = r64();
        req_valid = 1'b1; a0 = r64(); a1 = r64(); b0 = r64(); b1 = r64();
        @(negedge ap_clk);
        req_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk("tmo_res_valid", 64'(res_valid), 64'd0);
            chk("tmo_start", 64'(child_ap_start), 64'(c <= 2));
            child_ap_ready = (c == 2);
            child_s0_vld = (c == 3);
            child_s0 = v;
            @(negedge ap_clk);
        end
        child_ap_ready = 1'b0; child_s0_vld = 1'b0;
        chk("tmo_res_valid_16", 64'(res_valid), 64'd1);
        chk("tmo_err", 64'(err), 64'd1);
        chk("tmo_start_off", 64'(child_ap_start), 64'd0);
        chk("tmo_s0", s0, v);
        chk("tmo_s1", s1, exp_s1);
        exp_s0 = v;
        res_ready = 1'b1;
        @(negedge ap_clk);
        res_ready = 1'b0;
        chk("tmo_err_sticky", 64'(err), 64'd1);
        chk("tmo_idle", 64'(req_ready), 64'd1);
`endif

        req_valid = 1'b1; a0 = r64(); a1 = r64(); b0 = r64(); b1 = r64();
        @(negedge ap_clk);
        req_valid = 1'b0; child_ap_ready = 1'b1;
        @(negedge ap_clk);
        child_ap_ready = 1'b0;
        chk("pre_rst_start", 64'(child_ap_start), 64'd0);
        #3 ap_rst = 1'b1;
        #1;
        chk("arst_req_ready", 64'(req_ready), 64'd1);
        chk("arst_start", 64'(child_ap_start), 64'd0);
        chk("arst_res_valid", 64'(res_valid), 64'd0);
        chk("arst_s0", s0, 64'd0);
        chk("arst_s1", s1, 64'd0);
        chk("arst_child_a0", child_a0, 64'd0);
        chk("arst_child_b1", child_b1, 64'd0);
`ifdef VADD_LAUNCH_TIMEOUT_EN
        chk("arst_err", 64'(err), 64'd0);
`endif
        @(negedge ap_clk);
        ap_rst = 1'b0;
        exp_s0 = '0; exp_s1 = '0;
        run_txn(r64(), r64(), r64(), r64(), 1, 3, 1, 0, 0, 64'd0, 0);
        chk("post_rst_s1", s1, 64'd0);

        for (int i = 0; i < 25; i++) begin
            r = $urandom_range(0, 4);
            d = r + $urandom_range(0, 6);
            run_txn(r64(), r64(), r64(), r64(), r, d, 1'($urandom), 1'($urandom),
                    (d > 0) && 1'($urandom), r64(), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
